read_ptr_ctrl: RTL



---
 rtl/fifo_pkg.sv | 13 +
 rtl/gray2bin.sv | 14 +
 rtl/read_ptr_ctrl.sv | 92 +++++++++
 3 files changed

// File: rtl/fifo_pkg.sv
// Shared async-FIFO definitions: default pointer width, pointer type and the
// binary-to-Gray encoder used by both the read and write pointer controllers.
package fifo_pkg;

    localparam int PTR_WIDTH = 9;

    typedef logic [PTR_WIDTH:0] ptr_t;

    function automatic ptr_t bin2gray(input ptr_t bin);
        return bin ^ (bin >> 1);
    endfunction

endpackage

// File: rtl/gray2bin.sv
// Parameterized Gray-to-binary converter: each binary bit is the XOR of all
// Gray bits at or above its position.
module gray2bin #(
    parameter int W = 10
) (
    input  logic [W-1:0] gray_i,
    output logic [W-1:0] bin_o
);

    for (genvar i = 0; i < W; i++) begin : g_bit
        assign bin_o[i] = ^gray_i[W-1:i];
    end

endmodule

// File: rtl/read_ptr_ctrl.sv
// Read-domain pointer/empty controller for the async FIFO. Define RD_LEVEL_EN
// to compile in the conservative fill-level and almost-empty monitor.
module read_ptr_ctrl
    import fifo_pkg::*;
#(
    parameter int ptr_width = PTR_WIDTH,
    parameter int AE_THRESH = 4
) (
    input  logic               rclk,
    input  logic               r_rst_n,
    input  logic               r_en,
    input  logic [ptr_width:0] wptr_sync,
    output logic [ptr_width:0] raddr,
    output logic [ptr_width:0] rptr,
    output logic               empty,
    output logic               rvalid,
    output logic [ptr_width:0] rd_level,
    output logic               almost_empty
);

    localparam int PW = ptr_width + 1;

    logic [ptr_width:0] raddr_q, raddr_d;
    logic [ptr_width:0] rptr_q, rptr_d;
    logic               empty_q, empty_d;
    logic               rvalid_q, rvalid_d;
    logic               rd_accept;
    ptr_t               gray_full;

    always_comb begin
        rd_accept = r_en & ~empty_q;
        raddr_d   = raddr_q + PW'(rd_accept);
        gray_full = bin2gray(ptr_t'(raddr_d));
        rptr_d    = gray_full[ptr_width:0];
        // Full-width compare keeps the wrap bit, so full never looks empty.
        empty_d   = (rptr_d == wptr_sync);
        rvalid_d  = rd_accept;
    end

    always_ff @(posedge rclk or negedge r_rst_n) begin
        if (!r_rst_n) begin
            raddr_q  <= '0;
            rptr_q   <= '0;
            empty_q  <= 1'b1;
            rvalid_q <= 1'b0;
        end else begin
            raddr_q  <= raddr_d;
            rptr_q   <= rptr_d;
            empty_q  <= empty_d;
            rvalid_q <= rvalid_d;
        end
    end

    assign raddr  = raddr_q;
    assign rptr   = rptr_q;
    assign empty  = empty_q;
    assign rvalid = rvalid_q;

`ifdef RD_LEVEL_EN
    logic [ptr_width:0] wbin;
    logic [ptr_width:0] level_q, level_d;
    logic               ae_q, ae_d;

    gray2bin #(.W(PW)) u_gray2bin (
        .gray_i (wptr_sync),
        .bin_o  (wbin)
    );

    // Uses the lagging synchronized write pointer, so it can only under-report.
    always_comb begin
        level_d = wbin - raddr_d;
        ae_d    = (level_d <= PW'(AE_THRESH));
    end

    always_ff @(posedge rclk or negedge r_rst_n) begin
        if (!r_rst_n) begin
            level_q <= '0;
            ae_q    <= 1'b1;
        end else begin
            level_q <= level_d;
            ae_q    <= ae_d;
        end
    end

    assign rd_level     = level_q;
    assign almost_empty = ae_q;
`else
    assign rd_level     = '0;
    assign almost_empty = empty_q;
`endif

endmodule
